// File: rtl/lcd_pkg.sv
// Shared constants for the LCD pixel prefetch path: default panel geometry,
// colour width and a constant-evaluable ceil(log2) used to size counters.
package lcd_pkg;

    localparam int LCD_X_SIZE     = 240;
    localparam int LCD_Y_SIZE     = 240;
    localparam int LCD_COLOR_BITS = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_pixel_fifo.sv
// Small synchronous FIFO with a combinational head; the caller guarantees it
// never pushes when full nor pops when empty.
module lcd_pixel_fifo
    import lcd_pkg::*;
#(
    parameter int WIDTH = LCD_COLOR_BITS,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the counters alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/lcd_pixel_prefetch.sv
// Raster-order pixel prefetcher between a pipelined colour source and the LCD
// driver. Build with LCD_PREFETCH_UNDERRUN_EN to get the sticky underrun flag.
module lcd_pixel_prefetch
    import lcd_pkg::*;
#(
    parameter int C_x_size      = LCD_X_SIZE,
    parameter int C_y_size      = LCD_Y_SIZE,
    parameter int C_color_bits  = LCD_COLOR_BITS,
    parameter int C_fifo_depth  = 8,
    parameter int C_src_latency = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic [7:0]              src_x,
    output logic [7:0]              src_y,
    input  logic [C_color_bits-1:0] src_color,
    input  logic                    lcd_next_pixel,
    output logic [C_color_bits-1:0] lcd_color,
    output logic                    underrun
);

    localparam int CW = clog2(C_fifo_depth) + 1;

    logic [7:0]               src_x_q, src_x_d;
    logic [7:0]               src_y_q, src_y_d;
    logic [C_src_latency-1:0] valid_q, valid_d;
    logic [C_color_bits-1:0]  lcd_color_q, lcd_color_d;

    logic [CW-1:0]            fifo_count;
    logic [CW-1:0]            inflight_count;
    logic [CW:0]              credit_sum;
    logic                     fifo_empty, fifo_full;
    logic                     fifo_push, fifo_pop;
    logic [C_color_bits-1:0]  fifo_head;
    logic                     issue;

    // A request is only issued when a FIFO slot is reserved for its colour.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < C_src_latency; i++) begin
            inflight_count = inflight_count + CW'(valid_q[i]);
        end
        credit_sum = {1'b0, fifo_count} + {1'b0, inflight_count};
        issue      = (credit_sum < (CW+1)'(C_fifo_depth));
    end

    always_comb begin
        src_x_d = src_x_q;
        src_y_d = src_y_q;
        if (issue) begin
            if (src_x_q == 8'(C_x_size - 1)) begin
                src_x_d = '0;
                src_y_d = (src_y_q == 8'(C_y_size - 1)) ? 8'd0 : src_y_q + 8'd1;
            end else begin
                src_x_d = src_x_q + 8'd1;
            end
        end
    end

    always_comb begin
        valid_d    = '0;
        valid_d[0] = issue;
        for (int i = 1; i < C_src_latency; i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

    assign fifo_push   = valid_q[C_src_latency-1] && !fifo_full;
    assign fifo_pop    = lcd_next_pixel && !fifo_empty;
    assign lcd_color_d = fifo_pop ? fifo_head : lcd_color_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            src_x_q     <= '0;
            src_y_q     <= '0;
            valid_q     <= '0;
            lcd_color_q <= '0;
        end else begin
            src_x_q     <= src_x_d;
            src_y_q     <= src_y_d;
            valid_q     <= valid_d;
            lcd_color_q <= lcd_color_d;
        end
    end

    lcd_pixel_fifo #(
        .WIDTH (C_color_bits),
        .DEPTH (C_fifo_depth)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (src_color),
        .dout   (fifo_head),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

`ifdef LCD_PREFETCH_UNDERRUN_EN
    logic underrun_q, underrun_d;

    assign underrun_d = underrun_q | (lcd_next_pixel & fifo_empty);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

    assign src_x     = src_x_q;
    assign src_y     = src_y_q;
    assign lcd_color = lcd_color_q;

endmodule

// File: tb/tb_lcd_pixel_prefetch.sv
// Scoreboard bench for lcd_pixel_prefetch: a 2-cycle {y,x} colour source and
// a raster model whose expected colours are queued at each pop pulse.
module tb_lcd_pixel_prefetch;

    localparam int XS = 240;
    localparam int YS = 240;
    localparam int CB = 16;
    localparam int FD = 8;
    localparam int SL = 2;

`ifdef LCD_PREFETCH_UNDERRUN_EN
    localparam logic UNDERRUN_EXP = 1'b1;
`else
    localparam logic UNDERRUN_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    src_x, src_y;
    logic [CB-1:0] src_color;
    logic          lcd_next_pixel = 1'b0;
    logic [CB-1:0] lcd_color;
    logic          underrun;
    logic [CB-1:0] src_d1, src_d2;

    int            total = 0;
    int            bad = 0;
    logic [CB-1:0] sb_q[$];
    int            exp_x = 0;
    int            exp_y = 0;
    logic [CB-1:0] last_exp = '0;
    bit            pend = 1'b0;

    lcd_pixel_prefetch #(
        .C_x_size      (XS),
        .C_y_size      (YS),
        .C_color_bits  (CB),
        .C_fifo_depth  (FD),
        .C_src_latency (SL)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .src_x          (src_x),
        .src_y          (src_y),
        .src_color      (src_color),
        .lcd_next_pixel (lcd_next_pixel),
        .lcd_color      (lcd_color),
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    // Colour source: returns {y,x} of the request made two cycles earlier.
    always @(posedge clk) begin
        src_d1 <= {src_y, src_x};
        src_d2 <= src_d1;
    end
    assign src_color = src_d2;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelNext(output logic [CB-1:0] c);
        c        = {exp_y[7:0], exp_x[7:0]};
        last_exp = c;
        exp_x++;
        if (exp_x == XS) begin
            exp_x = 0;
            exp_y++;
            if (exp_y == YS) exp_y = 0;
        end
    endtask

    task automatic modelReset();
        sb_q.delete();
        exp_x    = 0;
        exp_y    = 0;
        last_exp = '0;
    endtask

    // One pop pulse every 'period' cycles; 'hits' says whether the FIFO holds data.
    task automatic applyStimulus(input int n_pops, input int period, input bit hits);
        logic [CB-1:0] c;
        for (int i = 0; i < n_pops; i++) begin
            @(posedge clk);
            #1;
            lcd_next_pixel = 1'b1;
            if (hits) begin
                modelNext(c);
                sb_q.push_back(c);
            end else begin
                sb_q.push_back(last_exp);
            end
            if (period > 1) begin
                @(posedge clk);
                #1;
                lcd_next_pixel = 1'b0;
                repeat (period - 2) @(posedge clk);
            end
        end
        @(posedge clk);
        #1;
        lcd_next_pixel = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        lcd_next_pixel = 1'b0;
        resetn = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Compare the colour one edge after each pulse the DUT saw.
    always @(negedge clk) begin
        if (pend && sb_q.size() > 0) begin
            checkOutput("color", 32'(lcd_color), 32'(sb_q.pop_front()));
        end
        pend = lcd_next_pixel;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_src_x", 32'(src_x), 32'd0);
        checkOutput("rst_src_y", 32'(src_y), 32'd0);
        checkOutput("rst_lcd_color", 32'(lcd_color), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_fifo_count", 32'(dut.fifo_count), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        $display("[TB] reset fill");
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("fill_count_9", 32'(dut.fifo_count), 32'd7);
        @(posedge clk);
        @(negedge clk);
        checkOutput("fill_count_10", 32'(dut.fifo_count), 32'd8);
        checkOutput("fill_src_x", 32'(src_x), 32'd8);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("fill_src_x_hold", 32'(src_x), 32'd8);
        checkOutput("fill_src_y", 32'(src_y), 32'd0);

        $display("[TB] push and pop together");
        applyStimulus(1, 1, 1'b1);
        @(negedge clk);
        checkOutput("pp_count_dip", 32'(dut.fifo_count), 32'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("pp_count_still", 32'(dut.fifo_count), 32'd7);
        @(posedge clk);
        @(negedge clk);
        checkOutput("pp_count_back", 32'(dut.fifo_count), 32'd8);

        $display("[TB] ordering");
        applyStimulus(250, 16, 1'b1);

        $display("[TB] frame wrap");
        applyStimulus(XS * YS - 251, 1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("wrap_src_y", 32'(src_y), 32'd0);
        checkOutput("wrap_src_x", 32'(src_x), 32'd8);
        checkOutput("wrap_count", 32'(dut.fifo_count), 32'd8);
        applyStimulus(1, 1, 1'b1);
        @(negedge clk);
        checkOutput("wrap_no_underrun", 32'(underrun), 32'd0);

        $display("[TB] underrun");
        doReset();
        lcd_next_pixel = 1'b1;
        sb_q.push_back(last_exp);
        @(posedge clk);
        #1;
        lcd_next_pixel = 1'b0;
        @(negedge clk);
        checkOutput("underrun_set", 32'(underrun), 32'(UNDERRUN_EXP));
        repeat (8) @(posedge clk);
        applyStimulus(1, 1, 1'b1);
        @(negedge clk);
        checkOutput("underrun_sticky", 32'(underrun), 32'(UNDERRUN_EXP));

        $display("[TB] reset mid-frame");
        doReset();
        checkOutput("rst2_underrun", 32'(underrun), 32'd0);
        repeat (12) @(posedge clk);
        applyStimulus(1000, 1, 1'b1);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        modelReset();
        #1;
        checkOutput("async_src_x", 32'(src_x), 32'd0);
        checkOutput("async_src_y", 32'(src_y), 32'd0);
        checkOutput("async_lcd_color", 32'(lcd_color), 32'd0);
        checkOutput("async_underrun", 32'(underrun), 32'd0);
        checkOutput("async_fifo_count", 32'(dut.fifo_count), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (12) @(posedge clk);
        applyStimulus(3, 16, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("final_underrun", 32'(underrun), 32'd0);
        checkOutput("sb_left", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
